// File: rtl/i_raster_scanner_if.sv
// rtl/i_raster_scanner_if.sv - coordinate stream between the raster scanner and its consumer
// Optional border flag is present only when RASTER_BORDER_EN is defined.
interface i_raster_scanner_if #(
  parameter int DIM_W  = 13,
  parameter int ADDR_W = 26
);
  logic              out_valid;
  logic              out_ready;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              line_end;
  logic              frame_end;
`ifdef RASTER_BORDER_EN
  logic              border;
`endif

  modport master (
    output out_valid, col, row, addr, line_end, frame_end,
`ifdef RASTER_BORDER_EN
    output border,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, col, row, addr, line_end, frame_end,
`ifdef RASTER_BORDER_EN
    input  border,
`endif
    output out_ready
  );
endinterface

// File: rtl/i_raster_scanner.sv
// rtl/i_raster_scanner.sv - raster-order (row, col, addr) generator with valid/ready stalls
// Define RASTER_BORDER_EN to add the image-border flag on the stream.
module i_raster_scanner #(
  parameter int DIM_W  = 13,
  parameter int ADDR_W = 26
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  output logic             busy,
  output logic             done,
  i_raster_scanner_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DIM_W-1:0]  width_q;
  logic [DIM_W-1:0]  height_q;
  logic [DIM_W-1:0]  col_q;
  logic [DIM_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;

  logic [DIM_W-1:0]  last_col;
  logic [DIM_W-1:0]  last_row;
  logic              at_col_end;
  logic              at_row_end;
  logic              scan_valid;
  logic              xfer;
  logic              empty_dims;

  // Dimensions are nonzero whenever SCAN is entered, so the minus-one never wraps there.
  assign last_col   = width_q - DIM_W'(1);
  assign last_row   = height_q - DIM_W'(1);
  assign at_col_end = (col_q == last_col);
  assign at_row_end = (row_q == last_row);
  assign xfer       = scan_valid & bus.out_ready;
  assign empty_dims = (img_width == '0) | (img_height == '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = empty_dims ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (xfer && at_col_end && at_row_end) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scan_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      SCAN: begin
        scan_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Indices return to zero after the final beat so the idle stream fields read 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        width_q  <= img_width;
        height_q <= img_height;
        col_q    <= '0;
        row_q    <= '0;
        addr_q   <= '0;
      end
    end else if (xfer) begin
      if (!at_col_end) begin
        col_q  <= col_q + DIM_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end else if (!at_row_end) begin
        col_q  <= '0;
        row_q  <= row_q + DIM_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end else begin
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= '0;
      end
    end
  end

  assign bus.out_valid = scan_valid;
  assign bus.col       = col_q;
  assign bus.row       = row_q;
  assign bus.addr      = addr_q;
  assign bus.line_end  = scan_valid & at_col_end;
  assign bus.frame_end = scan_valid & at_col_end & at_row_end;

`ifdef RASTER_BORDER_EN
  assign bus.border = scan_valid &
                      ((col_q == '0) | at_col_end | (row_q == '0) | at_row_end);
`endif

endmodule
